// File: rtl/hs_rr_arbiter_if.sv
// Bundle of the upstream and downstream 4-phase channels of hs_rr_arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface hs_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 37
);
    localparam int unsigned GrantW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]        ack_o;
    logic                      req_o;
    logic [DATA_W-1:0]         data_o;
    logic                      ack_i;
    logic [GrantW-1:0]         grant_o;
    logic                      busy_o;
    logic                      err_o;

    modport slave (
        input  req_i, data_i, ack_i,
        output ack_o, req_o, data_o, grant_o, busy_o, err_o
    );

    modport master (
        output req_i, data_i, ack_i,
        input  ack_o, req_o, data_o, grant_o, busy_o, err_o
    );
endinterface

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack channel among NUM_REQ requesters.
// Completes the full 4-phase cycle on both sides before re-arbitrating; all outputs registered.
module hs_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 37
) (
    input logic          clk_i,
    input logic          rst_ni,
    hs_rr_arbiter_if.slave bus
);
    localparam int unsigned GrantW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StAcked, StRelease} state_e;

    state_e               state_q, state_d;
    logic [GrantW-1:0]    ptr_q, ptr_d;
    logic [GrantW-1:0]    grant_q, grant_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 req_q, req_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [GrantW-1:0]    win;
    logic                 found;

    // Scan ptr+1, ptr+2, ... with wrap; first set request wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            logic [GrantW-1:0] idx;
            idx = GrantW'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && bus.req_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        req_d   = req_q;
        ack_d   = ack_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.ack_i) begin
                    err_d = 1'b1;
                end else if (found) begin
                    grant_d = win;
                    data_d  = bus.data_i[32'(win)*DATA_W +: DATA_W];
                    req_d   = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!bus.req_i[grant_q]) err_d = 1'b1;
                if (bus.ack_i) begin
                    ack_d          = '0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = StAcked;
                end
            end
            StAcked: begin
                if (!bus.ack_i) err_d = 1'b1;
                if (!bus.req_i[grant_q]) begin
                    req_d   = 1'b0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (bus.req_i[grant_q]) err_d = 1'b1;
                if (!bus.ack_i) begin
                    ack_d   = '0;
                    ptr_d   = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= GrantW'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.req_o   = req_q;
    assign bus.data_o  = data_q;
    assign bus.grant_o = grant_q;
    assign bus.busy_o  = busy_q;
    assign bus.err_o   = err_q;
endmodule
